// File: rtl/mdio_pkg.sv
// Shared constants for the Clause-22 MDIO responder: field widths, opcodes and
// the FSM state encoding.
package mdio_pkg;

  localparam int unsigned PHYAD_W = 5;
  localparam int unsigned REGAD_W = 5;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TA_LEN  = 2;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // FSM state encoding, kept as plain constants so older tools accept it.
  typedef logic [3:0] mdio_state_t;

  localparam mdio_state_t StIdle  = 4'd0;
  localparam mdio_state_t StStart = 4'd1;
  localparam mdio_state_t StOp    = 4'd2;
  localparam mdio_state_t StPhyad = 4'd3;
  localparam mdio_state_t StRegad = 4'd4;
  localparam mdio_state_t StTa    = 4'd5;
  localparam mdio_state_t StWdata = 4'd6;
  localparam mdio_state_t StRdata = 4'd7;
  localparam mdio_state_t StSkip  = 4'd8;

endpackage

// File: rtl/mdio_sync_edge.sv
// Synchronizers for MDC and MDIO (same depth, so they stay aligned) plus a
// one-clk pulse on each rising edge of the synchronized MDC.
module mdio_sync_edge #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic rise_o,
  output logic mdio_o
);

  logic [SyncStages-1:0] mdc_q;
  logic [SyncStages-1:0] mdio_q;
  logic                  mdc_prev_q;

  // Synchronizer chains; reset to the idle-high level so leaving reset while
  // MDC is high does not fabricate a rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mdc_q      <= '1;
      mdio_q     <= '1;
      mdc_prev_q <= 1'b1;
    end else begin
      mdc_q[0]  <= mdc_i;
      mdio_q[0] <= mdio_i;
      for (int i = 1; i < int'(SyncStages); i++) begin
        mdc_q[i]  <= mdc_q[i-1];
        mdio_q[i] <= mdio_q[i-1];
      end
      mdc_prev_q <= mdc_q[SyncStages-1];
    end
  end

  // Rising-edge pulse and the MDIO bit that goes with it.
  always_comb begin
    rise_o = mdc_q[SyncStages-1] & ~mdc_prev_q;
    mdio_o = mdio_q[SyncStages-1];
  end

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side). Decodes read/write frames addressed to
// phy_addr_i, strobes a 32x16 register backend and drives read data on MDIO.
// Optional: define MDIO_PREAMBLE_SUPPRESS_EN to accept a frame after a single
// idle 1 following a completed addressed frame.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               mdc_i,
  input  logic               mdio_in_i,
  output logic               mdio_out_o,
  output logic               mdio_oe_o,
  input  logic [PHYAD_W-1:0] phy_addr_i,
  output logic [REGAD_W-1:0] reg_addr_o,
  output logic               reg_rd_o,
  input  logic [DATA_W-1:0]  reg_rdata_i,
  output logic               reg_wr_o,
  output logic [DATA_W-1:0]  reg_wdata_o,
  output logic               frame_err_o
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic SuppEn = 1'b1;
`else
  localparam logic SuppEn = 1'b0;
`endif

  localparam int unsigned PreW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PreW-1:0] PreFull = PreW'(PREAMBLE_LEN);

  logic rise;
  logic mdio_bit;

  mdio_sync_edge #(
    .SyncStages(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .mdc_i (mdc_i),
    .mdio_i(mdio_in_i),
    .rise_o(rise),
    .mdio_o(mdio_bit)
  );

  mdio_state_t         state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [4:0]          skip_last_q, skip_last_d;
  logic [PreW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [REGAD_W-1:0]  reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                reg_rd_q, reg_rd_d;
  logic                reg_wr_q, reg_wr_d;
  logic                frame_err_q, frame_err_d;
  logic                mdio_out_q, mdio_out_d;
  logic                mdio_oe_q, mdio_oe_d;
  logic                supp_ok_q, supp_ok_d;
  logic                rd_dly_q;

  logic [DATA_W-1:0]  shift_in;
  logic [PHYAD_W-1:0] field5;
  logic [1:0]         op_in;

  assign shift_in = {shift_q[DATA_W-2:0], mdio_bit};
  assign field5   = {shift_q[PHYAD_W-2:0], mdio_bit};
  assign op_in    = {op_q[0], mdio_bit};

  // Frame decoder: every transition is qualified by a synchronized MDC rise.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    skip_last_d = skip_last_q;
    pre_cnt_d   = pre_cnt_q;
    op_d        = op_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_rd_d    = 1'b0;
    reg_wr_d    = 1'b0;
    frame_err_d = 1'b0;
    mdio_out_d  = mdio_out_q;
    mdio_oe_d   = mdio_oe_q;
    supp_ok_d   = supp_ok_q;

    // Backend read data is valid the clk after the strobe.
    if (rd_dly_q) begin
      shift_d = reg_rdata_i;
    end

    if (rise) begin
      case (state_q)
        StIdle: begin
          if (mdio_bit) begin
            if (supp_ok_q) begin
              pre_cnt_d = PreFull;
            end else if (pre_cnt_q != PreFull) begin
              pre_cnt_d = pre_cnt_q + 1'b1;
            end
          end else begin
            if (pre_cnt_q == PreFull) begin
              state_d   = StStart;
              supp_ok_d = 1'b0;
            end
            pre_cnt_d = '0;
          end
        end
        StStart: begin
          bit_cnt_d = '0;
          state_d   = mdio_bit ? StOp : StIdle;
        end
        StOp: begin
          op_d = op_in;
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = '0;
            state_d   = (op_in == OP_READ || op_in == OP_WRITE) ? StPhyad : StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StPhyad: begin
          shift_d = shift_in;
          if (bit_cnt_q == 5'(PHYAD_W - 1)) begin
            bit_cnt_d = '0;
            if (field5 == phy_addr_i) begin
              state_d = StRegad;
            end else begin
              state_d     = StSkip;
              skip_last_d = 5'(TA_LEN + DATA_W - 1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StRegad: begin
          shift_d = shift_in;
          if (bit_cnt_q == 5'(REGAD_W - 1)) begin
            bit_cnt_d  = '0;
            reg_addr_d = field5;
            reg_rd_d   = (op_q == OP_READ);
            state_d    = StTa;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StTa: begin
          if (op_q == OP_READ) begin
            if (bit_cnt_q == 5'd0) begin
              // Drive the PHY half of turnaround (a 0) for the next rise.
              mdio_oe_d  = 1'b1;
              mdio_out_d = 1'b0;
              bit_cnt_d  = 5'd1;
            end else begin
              mdio_out_d = shift_q[DATA_W-1];
              shift_d    = {shift_q[DATA_W-2:0], 1'b0};
              bit_cnt_d  = '0;
              state_d    = StRdata;
            end
          end else begin
            shift_d = shift_in;
            if (bit_cnt_q == 5'd0) begin
              bit_cnt_d = 5'd1;
            end else begin
              bit_cnt_d = '0;
              if ({shift_q[0], mdio_bit} == 2'b10) begin
                state_d = StWdata;
              end else begin
                frame_err_d = 1'b1;
                state_d     = StSkip;
                skip_last_d = 5'(DATA_W - 1);
              end
            end
          end
        end
        StRdata: begin
          // Rises 0..14 launch D14..D0, rise 15 is the D0 sample, rise 16 releases.
          if (bit_cnt_q < 5'(DATA_W - 1)) begin
            mdio_out_d = shift_q[DATA_W-1];
            shift_d    = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 5'd1;
          end else if (bit_cnt_q == 5'(DATA_W - 1)) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end else begin
            mdio_oe_d  = 1'b0;
            mdio_out_d = 1'b1;
            bit_cnt_d  = '0;
            pre_cnt_d  = '0;
            supp_ok_d  = SuppEn;
            state_d    = StIdle;
          end
        end
        StWdata: begin
          shift_d = shift_in;
          if (bit_cnt_q == 5'(DATA_W - 1)) begin
            reg_wdata_d = shift_in;
            reg_wr_d    = 1'b1;
            bit_cnt_d   = '0;
            pre_cnt_d   = '0;
            supp_ok_d   = SuppEn;
            state_d     = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StSkip: begin
          if (bit_cnt_q == skip_last_q) begin
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          pre_cnt_d = '0;
          mdio_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset releases MDIO on the same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      skip_last_q <= '0;
      pre_cnt_q   <= '0;
      op_q        <= '0;
      shift_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      mdio_out_q  <= 1'b1;
      mdio_oe_q   <= 1'b0;
      supp_ok_q   <= 1'b0;
      rd_dly_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      skip_last_q <= skip_last_d;
      pre_cnt_q   <= pre_cnt_d;
      op_q        <= op_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_rd_q    <= reg_rd_d;
      reg_wr_q    <= reg_wr_d;
      frame_err_q <= frame_err_d;
      mdio_out_q  <= mdio_out_d;
      mdio_oe_q   <= mdio_oe_d;
      supp_ok_q   <= supp_ok_d;
      rd_dly_q    <= reg_rd_q;
    end
  end

  // Registered outputs straight to the ports.
  always_comb begin
    mdio_out_o  = mdio_out_q;
    mdio_oe_o   = mdio_oe_q;
    reg_addr_o  = reg_addr_q;
    reg_rd_o    = reg_rd_q;
    reg_wr_o    = reg_wr_q;
    reg_wdata_o = reg_wdata_q;
    frame_err_o = frame_err_q;
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDIO initiator model, a 32x16 register backend,
// a table of whole frames and a few hand-written multi-cycle sequences.
module tb_mdio_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        host_d;
  logic        pad;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        reg_wr;
  logic [15:0] reg_wdata;
  logic        frame_err;

  always #5 clk = ~clk;

  // Open-drain style pad: the initiator releases to a pull-up (1) when reading.
  assign pad = mdio_oe ? mdio_out : host_d;

  mdio_responder dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .mdc_i      (mdc),
    .mdio_in_i  (pad),
    .mdio_out_o (mdio_out),
    .mdio_oe_o  (mdio_oe),
    .phy_addr_i (phy_addr),
    .reg_addr_o (reg_addr),
    .reg_rd_o   (reg_rd),
    .reg_rdata_i(reg_rdata),
    .reg_wr_o   (reg_wr),
    .reg_wdata_o(reg_wdata),
    .frame_err_o(frame_err)
  );

  // Register backend: mem[i] = A5C2 + i after reset, read data one clk late.
  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'hA5C2 + 16'(i);
      reg_rdata <= '0;
    end else begin
      if (reg_wr) mem[reg_addr] <= reg_wdata;
      if (reg_rd) reg_rdata <= mem[reg_addr];
    end
  end

  // Event monitors.
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cnt = 0, both_cnt = 0;
  logic [4:0]  last_waddr = '0, last_raddr = '0;
  logic [15:0] last_wdata = '0;
  always @(posedge clk) begin
    if (reg_wr) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= reg_addr;
      last_wdata <= reg_wdata;
    end
    if (reg_rd) begin
      rd_cnt     <= rd_cnt + 1;
      last_raddr <= reg_addr;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (mdio_oe) oe_cnt <= oe_cnt + 1;
    if (reg_rd && reg_wr) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One MDC cycle: drive on the falling edge, sample the pad on the rising edge.
  task automatic send_bit(input logic b, output logic s);
    mdc    = 1'b0;
    host_d = b;
    #(HALF);
    mdc = 1'b1;
    s   = pad;
    #(HALF);
  endtask

  task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] ph,
                             input logic [4:0] rg);
    logic s;
    logic [15:0] hdr;
    hdr = {2'b01, op, ph, rg, 2'b00};
    for (int i = 0; i < pre; i++) send_bit(1'b1, s);
    for (int i = 15; i >= 2; i--) send_bit(hdr[i], s);
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] data;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
    bit          exp_oe;
    logic [4:0]  exp_addr;
    logic [15:0] exp_wdata;
    bit          chk_samp;
    logic [17:0] exp_samp;
  } vec_t;

  // Whole frame: header, 18 TA+data bits (released when reading), one idle 1.
  task automatic run_frame(input vec_t v, output logic [17:0] samp);
    logic s;
    logic [17:0] pay;
    pay = {v.ta, v.data};
    send_header(v.pre, v.op, v.phyad, v.regad);
    for (int i = 17; i >= 0; i--) begin
      send_bit((v.op == 2'b10) ? 1'b1 : pay[i], s);
      samp[i] = s;
    end
    send_bit(1'b1, s);
  endtask

  vec_t vecs [10];

  initial begin
    logic [17:0] samp;
    logic        s;
    int w0, r0, e0, o0, exp_w;
    vec_t v;

    //          pre op     ph    rg    ta     data      wr rd er oe addr  wdata     cs samp
    vecs[0] = '{32, 2'b01, 5'd3, 5'd4, 2'b10, 16'hBEEF, 1, 0, 0, 0, 5'd4, 16'hBEEF, 0, 18'h0};
    vecs[1] = '{32, 2'b10, 5'd3, 5'd1, 2'b00, 16'h0000, 0, 1, 0, 1, 5'd1, 16'h0,    1, 18'h2A5C3};
    vecs[2] = '{32, 2'b10, 5'd5, 5'd1, 2'b00, 16'h0000, 0, 0, 0, 0, 5'd0, 16'h0,    1, 18'h3FFFF};
    vecs[3] = '{32, 2'b01, 5'd3, 5'd7, 2'b11, 16'h1234, 0, 0, 1, 0, 5'd0, 16'h0,    0, 18'h0};
    vecs[4] = '{32, 2'b01, 5'd3, 5'd2, 2'b10, 16'h5A0F, 1, 0, 0, 0, 5'd2, 16'h5A0F, 0, 18'h0};
    vecs[5] = '{32, 2'b10, 5'd3, 5'd4, 2'b00, 16'h0000, 0, 1, 0, 1, 5'd4, 16'h0,    1, 18'h2BEEF};
    vecs[6] = '{32, 2'b01, 5'd3, 5'd3, 2'b00, 16'hFFFF, 0, 0, 1, 0, 5'd0, 16'h0,    0, 18'h0};
    vecs[7] = '{32, 2'b00, 5'd3, 5'd2, 2'b10, 16'hABCD, 0, 0, 0, 0, 5'd0, 16'h0,    0, 18'h0};
    vecs[8] = '{32, 2'b11, 5'd3, 5'd2, 2'b10, 16'h1357, 0, 0, 0, 0, 5'd0, 16'h0,    0, 18'h0};
    vecs[9] = '{32, 2'b10, 5'd3, 5'd2, 2'b00, 16'h0000, 0, 1, 0, 1, 5'd2, 16'h0,    1, 18'h25A0F};

    rst      = 1'b1;
    mdc      = 1'b0;
    host_d   = 1'b1;
    phy_addr = 5'd3;
    repeat (5) @(negedge clk);
    chk("rst_mdio_out", 32'(mdio_out), 32'd1);
    chk("rst_mdio_oe", 32'(mdio_oe), 32'd0);
    chk("rst_reg_rd", 32'(reg_rd), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cnt;
      run_frame(vecs[k], samp);
      @(negedge clk);
      chk($sformatf("v%0d_wr", k), 32'(wr_cnt - w0), 32'(vecs[k].exp_wr));
      chk($sformatf("v%0d_rd", k), 32'(rd_cnt - r0), 32'(vecs[k].exp_rd));
      chk($sformatf("v%0d_err", k), 32'(err_cnt - e0), 32'(vecs[k].exp_err));
      chk($sformatf("v%0d_oe_seen", k), 32'(oe_cnt != o0), 32'(vecs[k].exp_oe));
      chk($sformatf("v%0d_oe_end", k), 32'(mdio_oe), 32'd0);
      if (vecs[k].exp_wr != 0) begin
        chk($sformatf("v%0d_waddr", k), 32'(last_waddr), 32'(vecs[k].exp_addr));
        chk($sformatf("v%0d_wdata", k), 32'(last_wdata), 32'(vecs[k].exp_wdata));
      end
      if (vecs[k].exp_rd != 0) begin
        chk($sformatf("v%0d_raddr", k), 32'(last_raddr), 32'(vecs[k].exp_addr));
      end
      if (vecs[k].chk_samp) begin
        chk($sformatf("v%0d_mdio_bits", k), 32'(samp), 32'(vecs[k].exp_samp));
      end
    end

    // 31-one preamble must not decode; a following full preamble must.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    w0 = wr_cnt;
    v = '{31, 2'b01, 5'd3, 5'd9, 2'b10, 16'h1111, 0, 0, 0, 0, 5'd0, 16'h0, 0, 18'h0};
    run_frame(v, samp);
    @(negedge clk);
    chk("short_pre_no_wr", 32'(wr_cnt - w0), 32'd0);
    v.pre = 32;
    run_frame(v, samp);
    @(negedge clk);
    chk("full_pre_wr", 32'(wr_cnt - w0), 32'd1);
    chk("full_pre_wdata", 32'(last_wdata), 32'h1111);

    // Reset during the read data phase releases MDIO on the next clk.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_header(32, 2'b10, 5'd3, 5'd1);
    for (int i = 17; i >= 8; i--) begin
      send_bit(1'b1, s);
      samp[i] = s;
    end
    chk("midread_ta_d15_d8", 32'(samp[16:8]), 32'h0A5);
    @(negedge clk);
    chk("midread_oe_before", 32'(mdio_oe), 32'd1);
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("midread_oe_after", 32'(mdio_oe), 32'd0);
    chk("midread_out_after", 32'(mdio_out), 32'd1);
    rst = 1'b0;
    o0 = oe_cnt;
    for (int i = 0; i < 9; i++) send_bit(1'b1, s);
    @(negedge clk);
    chk("midread_no_strobe", 32'((wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0)), 32'd0);
    chk("midread_no_drive", 32'(oe_cnt - o0), 32'd0);
    v = '{32, 2'b01, 5'd3, 5'd6, 2'b10, 16'h0F0F, 0, 0, 0, 0, 5'd0, 16'h0, 0, 18'h0};
    run_frame(v, samp);
    @(negedge clk);
    chk("midread_recover_wr", 32'(wr_cnt - w0), 32'd1);
    chk("midread_recover_addr", 32'(last_waddr), 32'd6);

    // Back-to-back writes separated by one idle 1.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    w0 = wr_cnt;
    v = '{32, 2'b01, 5'd3, 5'd5, 2'b10, 16'h1357, 0, 0, 0, 0, 5'd0, 16'h0, 0, 18'h0};
    run_frame(v, samp);
    v = '{0, 2'b01, 5'd3, 5'd6, 2'b10, 16'h2468, 0, 0, 0, 0, 5'd0, 16'h0, 0, 18'h0};
    run_frame(v, samp);
    @(negedge clk);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    exp_w = 2;
    chk("b2b_last_wdata", 32'(last_wdata), 32'h2468);
`else
    exp_w = 1;
    chk("b2b_last_wdata", 32'(last_wdata), 32'h1357);
`endif
    chk("b2b_wr_count", 32'(wr_cnt - w0), 32'(exp_w));

    chk("no_dual_strobe", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
